muldiv_unit: RTL and testbench

//  Iterative unsigned multiply/divide execution unit for the RISC core.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 125 ++++++++++++
 tb/tb_muldiv_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Issue/write-back bundle between the core and the iterative multiply/divide unit.
// The master side issues operations; the slave side (the unit) returns a register-file write.
interface muldiv_unit_if #(
  parameter int unsigned W = 32
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   rd;
  logic         busy;
  logic         we;
  logic [4:0]   wa;
  logic [W-1:0] wd;

  modport master (
    output start, op, a, b, rd,
    input  busy, we, wa, wd
  );

  modport slave (
    input  start, op, a, b, rd,
    output busy, we, wa, wd
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply, restoring divide.
// One op every W+2 cycles: W iteration cycles, one result-load cycle, one write-back cycle.
module muldiv_unit #(
  parameter int unsigned W = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [4:0]     rd_q, rd_d;
  // Multiplicand for MUL, divisor for DIV.
  logic [W-1:0]   opd_q, opd_d;
  // hi: product upper half / partial remainder; lo: multiplier+product lower half / quotient.
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [4:0]     wa_q, wa_d;
  logic [W-1:0]   wd_q, wd_d;

  logic           accept;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_sub;

  assign bus.busy = (state_q != StIdle);
  assign bus.we   = (state_q == StDone);
  assign bus.wa   = wa_q;
  assign bus.wd   = wd_q;

  // Next-state and datapath: accept, iterate, load result, write back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    accept  = 1'b0;

    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    // Partial remainder is W+1 bits wide before the trial subtraction.
    div_shift = {hi_q, lo_q[W-1]};
    div_ge    = (div_shift >= {1'b0, opd_q});
    // When div_ge holds the difference is below 2^W, so W-bit wraparound is exact.
    div_sub   = div_shift[W-1:0] - opd_q;

    unique case (state_q)
      StIdle: begin
        accept = bus.start;
      end
      StCalc: begin
        if (cnt_q == CW'(W)) begin
          wa_d    = rd_q;
          wd_d    = op_q[0] ? hi_q : lo_q;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!op_q[1]) begin
            hi_d = mul_sum[W:1];
            lo_d = {mul_sum[0], lo_q[W-1:1]};
          end else if (div_ge) begin
            hi_d = div_sub;
            lo_d = {lo_q[W-2:0], 1'b1};
          end else begin
            hi_d = div_shift[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b0};
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        // Back-to-back issue is allowed on the edge leaving write-back.
        accept  = bus.start;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = StCalc;
      cnt_d   = '0;
      op_d    = bus.op;
      rd_d    = bus.rd;
      opd_d   = bus.op[1] ? bus.b : bus.a;
      hi_d    = '0;
      lo_d    = bus.op[1] ? bus.a : bus.b;
    end
  end

  // State and datapath registers with synchronous reset (reset also drops a pending start).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected write-backs are queued at issue, popped on we.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  muldiv_unit_if #(.W(W)) bus ();

  muldiv_unit #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_we  = 0;
  int unsigned n_ops = 0;

  logic [4:0]   exp_wa_q[$];
  logic [W-1:0] exp_wd_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic, written from the operation definitions.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == '0) ? '1 : a / b;
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  task automatic push(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] rd);
    exp_wa_q.push_back(rd);
    exp_wd_q.push_back(model(op, a, b));
    n_ops++;
  endtask

  // Write-back monitor: every we pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      n_we++;
      if (exp_wd_q.size() == 0) begin
        check("spurious_we", bus.we, 1'b0);
      end else begin
        check("wa", bus.wa, exp_wa_q.pop_front());
        check("wd", bus.wd, exp_wd_q.pop_front());
      end
    end
  end

  task automatic drive(input logic s, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] rd);
    bus.start = s;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.rd    = rd;
  endtask

  // Issue one op from idle and check its busy window and write-back timing.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] rd);
    int busy_n;
    int we_n;
    int we_at;
    busy_n = 0;
    we_n   = 0;
    we_at  = 0;
    @(negedge clk);
    drive(1'b1, op, a, b, rd);
    @(posedge clk);
    push(op, a, b, rd);
    #1;
    drive(1'b0, 2'($urandom), $urandom, $urandom, 5'($urandom));
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.we) begin
        we_n++;
        we_at = c;
      end
      if (!bus.busy) break;
    end
    check({tag, "_busy_cycles"}, busy_n, W + 2);
    check({tag, "_we_count"}, we_n, 1);
    check({tag, "_we_cycle"}, we_at, W + 2);
  endtask

  task automatic wait_idle(input string tag);
    int c;
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check({tag, "_idle_timeout"}, (c >= 200), 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, '0, '0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_we", bus.we, 1'b0);
    check("rst_wa", bus.wa, 5'd0);
    check("rst_wd", bus.wd, '0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mullo_7x6", 2'd0, 32'd7, 32'd6, 5'd5);
    run_op("mulhi_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    run_op("mullo_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
    run_op("divu_100_7", 2'd2, 32'd100, 32'd7, 5'd11);
    run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 5'd12);
    run_op("divu_5_9", 2'd2, 32'd5, 32'd9, 5'd13);
    run_op("remu_5_9", 2'd3, 32'd5, 32'd9, 5'd14);
    run_op("divu_by0", 2'd2, 32'h1234, 32'd0, 5'd15);
    run_op("remu_by0", 2'd3, 32'h1234, 32'd0, 5'd16);

    // Starts during CALC are ignored; a start held through write-back launches the next op.
    @(negedge clk);
    drive(1'b1, 2'd0, 32'd3, 32'd4, 5'd7);
    @(posedge clk);
    push(2'd0, 32'd3, 32'd4, 5'd7);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      if (c == 5 || c == W || c == W + 2) drive(1'b1, 2'd0, 32'd9, 32'd9, 5'd8);
      else bus.start = 1'b0;
    end
    @(posedge clk);
    push(2'd0, 32'd9, 32'd9, 5'd8);
    #1;
    bus.start = 1'b0;
    check("b2b_busy", bus.busy, 1'b1);
    check("b2b_we_low", bus.we, 1'b0);
    wait_idle("b2b");

    // Reset in the middle of a divide aborts it without a write-back.
    @(negedge clk);
    drive(1'b1, 2'd2, 32'd1000, 32'd7, 5'd3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 2'd0, 32'd2, 32'd2, 5'd4);
    @(posedge clk);
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_we", bus.we, 1'b0);
    check("abort_wa", bus.wa, 5'd0);
    check("abort_wd", bus.wd, '0);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("abort_stays_idle", bus.busy, 1'b0);

    run_op("after_abort", 2'd2, 32'd1000, 32'd7, 5'd3);
    run_op("rd_zero", 2'd1, 32'h8000_0001, 32'h0000_0003, 5'd0);
    for (int i = 0; i < 4; i++) begin
      run_op("random", 2'(i), $urandom, (i == 3) ? 32'($urandom_range(1, 255)) : $urandom,
             5'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_wd_q.size(), 0);
    check("we_total", n_we, n_ops);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
